// File: rtl/bus_mon_pkg.sv
// ============================================================================
// bus_mon_pkg : shared state encoding and default constants for the monitor
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package bus_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERROR  = 2'd2
    } mon_state_t;

    localparam int c_DEF_NUM_CPUS         = 2;
    localparam int c_DEF_BLOCK_SIZE_WORDS = 2;
    localparam int c_DEF_TIMEOUT          = 25;

    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_mon_channel.sv
// ============================================================================
// bus_mon_channel : per-CPU block-transaction watcher (beat timeout, protocol)
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_mon_channel
    import bus_mon_pkg::*;
#(
    parameter int BLOCK_SIZE_WORDS = c_DEF_BLOCK_SIZE_WORDS,
    parameter int TIMEOUT          = c_DEF_TIMEOUT
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_ren,
    input  logic i_wen,
    input  logic i_dwait,
    input  logic i_clear,
    output logic o_timeout_err,
    output logic o_proto_err,
    output logic o_new_timeout,
    output logic o_new_proto
);

    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);
    localparam int c_BEAT_W = min1_clog2(BLOCK_SIZE_WORDS);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT   = c_WAIT_W'(TIMEOUT);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BLOCK_SIZE_WORDS - 1);

    mon_state_t          r_state;
    logic [c_WAIT_W-1:0] r_wait;
    logic [c_BEAT_W-1:0] r_beat;
    logic                r_timeout;
    logic                r_proto;

    logic                w_both;
    logic                w_one;
    logic [c_WAIT_W-1:0] w_wait_inc;
    logic                w_set_timeout;
    logic                w_set_proto;

    always_comb begin
        w_both        = i_ren & i_wen;
        w_one         = i_ren ^ i_wen;
        w_wait_inc    = r_wait + c_WAIT_W'(1);
        w_set_timeout = 1'b0;
        w_set_proto   = 1'b0;
        case (r_state)
            ST_IDLE:   w_set_proto = w_both;
            ST_ACTIVE: begin
                if (w_both || !w_one) begin
                    w_set_proto = 1'b1;
                end else if (i_dwait && (w_wait_inc == c_TIMEOUT)) begin
                    w_set_timeout = 1'b1;
                end
            end
            ST_ERROR:  w_set_proto = w_both;
            default:   w_set_proto = 1'b0;
        endcase
    end

    // A clear in the same cycle suppresses any error that would have been raised.
    assign o_new_timeout = w_set_timeout & ~r_timeout & ~i_clear;
    assign o_new_proto   = w_set_proto   & ~r_proto   & ~i_clear;
    assign o_timeout_err = r_timeout;
    assign o_proto_err   = r_proto;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_beat    <= '0;
            r_timeout <= 1'b0;
            r_proto   <= 1'b0;
        end else if (i_clear) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_beat    <= '0;
            r_timeout <= 1'b0;
            r_proto   <= 1'b0;
        end else begin
            if (w_set_timeout) r_timeout <= 1'b1;
            if (w_set_proto)   r_proto   <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_wait <= '0;
                    r_beat <= '0;
                    if (w_both) begin
                        r_state <= ST_ERROR;
                    end else if (w_one) begin
                        // A beat completing in the accept cycle counts as beat 0.
                        if (i_dwait) begin
                            r_state <= ST_ACTIVE;
                        end else if (c_LAST_BEAT != '0) begin
                            r_state <= ST_ACTIVE;
                            r_beat  <= c_BEAT_W'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_both) begin
                        r_state <= ST_ERROR;
                    end else if (!w_one) begin
                        r_state <= ST_IDLE;
                        r_wait  <= '0;
                        r_beat  <= '0;
                    end else if (!i_dwait) begin
                        r_wait <= '0;
                        if (r_beat == c_LAST_BEAT) begin
                            r_state <= ST_IDLE;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + c_BEAT_W'(1);
                        end
                    end else begin
                        r_wait <= w_wait_inc;
                        if (w_wait_inc == c_TIMEOUT) r_state <= ST_ERROR;
                    end
                end
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_timeout_monitor.sv
// ============================================================================
// bus_timeout_monitor : NUM_CPUS channel watchers plus shared error reporting
// Revision            : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_timeout_monitor
    import bus_mon_pkg::*;
#(
    parameter int NUM_CPUS         = c_DEF_NUM_CPUS,
    parameter int BLOCK_SIZE_WORDS = c_DEF_BLOCK_SIZE_WORDS,
    parameter int TIMEOUT          = c_DEF_TIMEOUT
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic [NUM_CPUS-1:0]                  dREN,
    input  logic [NUM_CPUS-1:0]                  dWEN,
    input  logic [NUM_CPUS-1:0]                  dwait,
    input  logic [NUM_CPUS-1:0]                  clear,
    output logic [NUM_CPUS-1:0]                  timeout_err,
    output logic [NUM_CPUS-1:0]                  proto_err,
    output logic                                 err_valid,
    output logic [min1_clog2(NUM_CPUS)-1:0]      err_cpu,
    output logic [7:0]                           err_count
);

    localparam int c_CPU_W = min1_clog2(NUM_CPUS);

    logic [NUM_CPUS-1:0] w_new_to;
    logic [NUM_CPUS-1:0] w_new_pr;
    logic [NUM_CPUS-1:0] w_new;
    logic [c_CPU_W-1:0]  w_first;
    logic [8:0]          w_add;
    logic [8:0]          w_sum;

    logic                r_err_valid;
    logic [c_CPU_W-1:0]  r_err_cpu;
    logic [7:0]          r_err_count;

    for (genvar g = 0; g < NUM_CPUS; g++) begin : g_ch
        bus_mon_channel #(
            .BLOCK_SIZE_WORDS (BLOCK_SIZE_WORDS),
            .TIMEOUT          (TIMEOUT)
        ) u_ch (
            .CLK           (CLK),
            .nRST          (nRST),
            .i_ren         (dREN[g]),
            .i_wen         (dWEN[g]),
            .i_dwait       (dwait[g]),
            .i_clear       (clear[g]),
            .o_timeout_err (timeout_err[g]),
            .o_proto_err   (proto_err[g]),
            .o_new_timeout (w_new_to[g]),
            .o_new_proto   (w_new_pr[g])
        );
    end

    // Descending scan so the lowest-index reporting channel wins.
    always_comb begin
        w_new   = w_new_to | w_new_pr;
        w_first = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--) begin
            if (w_new[i]) w_first = c_CPU_W'(i);
        end
        w_add = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            w_add = w_add + 9'(w_new_to[i]) + 9'(w_new_pr[i]);
        end
        w_sum = {1'b0, r_err_count} + w_add;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_err_valid <= 1'b0;
            r_err_cpu   <= '0;
            r_err_count <= '0;
        end else begin
            r_err_valid <= |w_new;
            if (|w_new) r_err_cpu <= w_first;
            r_err_count <= (w_sum > 9'd255) ? 8'hFF : w_sum[7:0];
        end
    end

    assign err_valid = r_err_valid;
    assign err_cpu   = r_err_cpu;
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_bus_timeout_monitor.sv
// ============================================================================
// tb_bus_timeout_monitor : vector table plus multi-cycle sequences, scoreboarded
// Revision               : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_timeout_monitor;

    logic       CLK;
    logic       nRST;
    logic [1:0] dREN, dWEN, dwait, clear;
    logic [1:0] timeout_err, proto_err;
    logic       err_valid;
    logic [0:0] err_cpu;
    logic [7:0] err_count;

    bus_timeout_monitor #(
        .NUM_CPUS         (2),
        .BLOCK_SIZE_WORDS (2),
        .TIMEOUT          (25)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .dwait       (dwait),
        .clear       (clear),
        .timeout_err (timeout_err),
        .proto_err   (proto_err),
        .err_valid   (err_valid),
        .err_cpu     (err_cpu),
        .err_count   (err_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] to;
        logic [1:0] pr;
        logic       ev;
        logic       cpu;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic [1:0] ren, wen, dw, clr;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt;

    function automatic exp_t mk_exp(input logic [1:0] to, input logic [1:0] pr,
                                    input logic ev, input logic cpu, input logic [7:0] cnt);
        exp_t e;
        e.to = to; e.pr = pr; e.ev = ev; e.cpu = cpu; e.cnt = cnt;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [1:0] ren, input logic [1:0] wen,
                                    input logic [1:0] dw, input logic [1:0] clr, input exp_t e);
        vec_t v;
        v.ren = ren; v.wen = wen; v.dw = dw; v.clr = clr; v.e = e;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_sb(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            cmp({nm, ".scoreboard_nonempty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        cmp({nm, ".timeout_err"}, 32'(timeout_err), 32'(e.to));
        cmp({nm, ".proto_err"},   32'(proto_err),   32'(e.pr));
        cmp({nm, ".err_valid"},   32'(err_valid),   32'(e.ev));
        cmp({nm, ".err_count"},   32'(err_count),   32'(e.cnt));
        if (e.ev) cmp({nm, ".err_cpu"}, 32'(err_cpu), 32'(e.cpu));
    endtask

    // Drive at the falling edge; outputs are judged at the next falling edge.
    task automatic step(input logic [1:0] ren, input logic [1:0] wen, input logic [1:0] dw,
                        input logic [1:0] clr, input exp_t e, input string nm);
        dREN = ren; dWEN = wen; dwait = dw; clear = clr;
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        check_sb(nm);
    endtask

    task automatic check_all_zero(input string nm);
        cmp({nm, ".timeout_err"}, 32'(timeout_err), 32'd0);
        cmp({nm, ".proto_err"},   32'(proto_err),   32'd0);
        cmp({nm, ".err_valid"},   32'(err_valid),   32'd0);
        cmp({nm, ".err_cpu"},     32'(err_cpu),     32'd0);
        cmp({nm, ".err_count"},   32'(err_count),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Clean 2-beat read with waits, then a request drop that must be harmless.
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        // Beat 0 completes in the accept cycle.
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        // Drop after beat 0, then both requests with the flag already set.
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0)));
        vecs.push_back(mk_vec(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b01, 1, 0, 8'd1)));
        vecs.push_back(mk_vec(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b01, 0, 0, 8'd1)));
        vecs.push_back(mk_vec(2'b01, 2'b01, 2'b00, 2'b00, mk_exp(2'b00, 2'b01, 0, 0, 8'd1)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b01, 0, 0, 8'd1)));
        vecs.push_back(mk_vec(2'b00, 2'b00, 2'b00, 2'b01, mk_exp(2'b00, 2'b00, 0, 0, 8'd1)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd1)));
        vecs.push_back(mk_vec(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd1)));
        vecs.push_back(mk_vec(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd1)));
        // CPU1 both requests while active.
        vecs.push_back(mk_vec(2'b00, 2'b10, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd1)));
        vecs.push_back(mk_vec(2'b10, 2'b10, 2'b11, 2'b00, mk_exp(2'b00, 2'b10, 1, 1, 8'd2)));
        vecs.push_back(mk_vec(2'b00, 2'b00, 2'b00, 2'b10, mk_exp(2'b00, 2'b00, 0, 0, 8'd2)));
        // Simultaneous protocol errors on both CPUs.
        vecs.push_back(mk_vec(2'b11, 2'b11, 2'b00, 2'b00, mk_exp(2'b00, 2'b11, 1, 0, 8'd4)));
        vecs.push_back(mk_vec(2'b11, 2'b11, 2'b00, 2'b00, mk_exp(2'b00, 2'b11, 0, 0, 8'd4)));
        vecs.push_back(mk_vec(2'b00, 2'b00, 2'b00, 2'b11, mk_exp(2'b00, 2'b00, 0, 0, 8'd4)));

        nRST = 1'b0; dREN = '0; dWEN = '0; dwait = '0; clear = '0;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        nRST = 1'b1;

        foreach (vecs[i])
            step(vecs[i].ren, vecs[i].wen, vecs[i].dw, vecs[i].clr, vecs[i].e,
                 $sformatf("vec%0d", i));
        ecnt = 4;

        // CPU1 write timeout: the 25th waiting cycle in ACTIVE trips it.
        step(2'b00, 2'b10, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "to1_acc");
        for (int k = 1; k <= 24; k++)
            step(2'b00, 2'b10, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), $sformatf("to1_w%0d", k));
        ecnt++;
        step(2'b00, 2'b10, 2'b11, 2'b00, mk_exp(2'b10, 2'b00, 1, 1, 8'(ecnt)), "to1_trip");
        step(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b10, 2'b00, 0, 0, 8'(ecnt)), "to1_hold");
        step(2'b00, 2'b00, 2'b00, 2'b10, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "to1_clr");
        step(2'b00, 2'b10, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "to1_post_b0");
        step(2'b00, 2'b10, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "to1_post_b1");
        step(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "to1_post_idle");

        // Both CPUs time out on the same cycle.
        step(2'b01, 2'b10, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "to2_acc");
        for (int k = 1; k <= 24; k++)
            step(2'b01, 2'b10, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), $sformatf("to2_w%0d", k));
        ecnt += 2;
        step(2'b01, 2'b10, 2'b11, 2'b00, mk_exp(2'b11, 2'b00, 1, 0, 8'(ecnt)), "to2_trip");
        step(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b11, 2'b00, 0, 0, 8'(ecnt)), "to2_hold");
        step(2'b00, 2'b00, 2'b00, 2'b11, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "to2_clr");

        // Clear arriving on the would-be timeout cycle wins.
        step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "cp_acc");
        for (int k = 1; k <= 24; k++)
            step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), $sformatf("cp_w%0d", k));
        step(2'b01, 2'b00, 2'b11, 2'b01, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "cp_trip");
        step(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), "cp_idle");

        // Asynchronous reset in the middle of a wait.
        ecnt++;
        step(2'b10, 2'b10, 2'b00, 2'b00, mk_exp(2'b00, 2'b10, 1, 1, 8'(ecnt)), "rst_pre_proto");
        step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b10, 0, 0, 8'(ecnt)), "rst_acc");
        for (int k = 1; k <= 20; k++)
            step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b10, 0, 0, 8'(ecnt)), $sformatf("rst_w%0d", k));
        #2 nRST = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge CLK);
        dREN = '0; dWEN = '0; dwait = '0;
        nRST = 1'b1;
        ecnt = 0;
        step(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0), "rel_idle");
        step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0), "rel_acc");
        for (int k = 1; k <= 24; k++)
            step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0), $sformatf("rel_w%0d", k));
        step(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0), "rel_b0");
        step(2'b01, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0), "rel_b1");
        step(2'b00, 2'b00, 2'b00, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'd0), "rel_done");

        // 300 timeouts with clears between: counter saturates at 255.
        for (int n = 1; n <= 300; n++) begin
            step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), $sformatf("sat%0d_acc", n));
            for (int k = 1; k <= 24; k++)
                step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), $sformatf("sat%0d_w", n));
            if (ecnt < 255) ecnt++;
            step(2'b01, 2'b00, 2'b11, 2'b00, mk_exp(2'b01, 2'b00, 1, 0, 8'(ecnt)), $sformatf("sat%0d_trip", n));
            step(2'b00, 2'b00, 2'b00, 2'b01, mk_exp(2'b00, 2'b00, 0, 0, 8'(ecnt)), $sformatf("sat%0d_clr", n));
        end
        cmp("sat_final", 32'(err_count), 32'd255);
        cmp("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
